// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response plus decode-side control and the IF/ID register.
// master = fetch stage, slave = memory and pipeline control around it.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd_data;
    logic        imem_rdy;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br_taken;
    logic [31:0] br_addr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_insn;
    logic        if_en;

    modport master (
        output imem_req, imem_addr, if_pc, if_pc_plus4, if_insn, if_en,
        input  imem_rd_data, imem_rdy, stall, flush, new_pc, br_taken, br_addr
    );

    modport slave (
        input  imem_req, imem_addr, if_pc, if_pc_plus4, if_insn, if_en,
        output imem_rd_data, imem_rdy, stall, flush, new_pc, br_taken, br_addr
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, one outstanding imem read, IF/ID written on the edge imem_rdy is sampled.
// Stall holds IF/ID and parks an early word in a one-entry buffer; redirects bubble IF/ID and retarget the PC.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master bus
);
    typedef enum logic [1:0] {ST_START, ST_BUSY, ST_DROP, ST_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] pc_q, pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_insn_q, buf_insn_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic [31:0] if_insn_q, if_insn_d;
    logic        if_en_q, if_en_d;

    logic        redirect;
    logic [31:0] target;
    logic        deliver;
    logic [31:0] dlv_pc;
    logic [31:0] dlv_insn;
    logic [31:0] drop_next;

    assign redirect = bus.flush | bus.br_taken;
    assign target   = bus.flush ? bus.new_pc : bus.br_addr;

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        pc_d        = pc_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_insn_d  = buf_insn_q;
        deliver     = 1'b0;
        dlv_pc      = req_addr_q;
        dlv_insn    = bus.imem_rd_data;
        drop_next   = redirect ? target : pc_q;

        case (state_q)
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (bus.imem_rdy) begin
                    if (redirect) begin
                        req_addr_d = target;
                        pc_d       = target + 32'd4;
                    end else if (bus.stall) begin
                        buf_valid_d = 1'b1;
                        buf_pc_d    = req_addr_q;
                        buf_insn_d  = bus.imem_rd_data;
                        state_d     = ST_HOLD;
                    end else begin
                        deliver    = 1'b1;
                        req_addr_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                    end
                end else if (redirect) begin
                    // The bus cannot retract a request, so the stale response is swallowed in DROP.
                    pc_d    = target;
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (redirect) pc_d = target;
                if (bus.imem_rdy) begin
                    req_addr_d = drop_next;
                    pc_d       = drop_next + 32'd4;
                    state_d    = ST_BUSY;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    buf_valid_d = 1'b0;
                    req_addr_d  = target;
                    pc_d        = target + 32'd4;
                    state_d     = ST_BUSY;
                end else if (!bus.stall && buf_valid_q) begin
                    deliver     = 1'b1;
                    dlv_pc      = buf_pc_q;
                    dlv_insn    = buf_insn_q;
                    buf_valid_d = 1'b0;
                    req_addr_d  = pc_q;
                    pc_d        = pc_q + 32'd4;
                    state_d     = ST_BUSY;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    always_comb begin
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_insn_d     = if_insn_q;
        if_en_d       = if_en_q;
        if (redirect) begin
            if_en_d   = 1'b0;
            if_insn_d = NOP_INSN;
        end else if (!bus.stall) begin
            if (deliver) begin
                if_pc_d       = dlv_pc;
                if_pc_plus4_d = dlv_pc + 32'd4;
                if_insn_d     = dlv_insn;
                if_en_d       = 1'b1;
            end else begin
                if_en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_START;
            req_addr_q    <= RESET_PC;
            pc_q          <= RESET_PC + 32'd4;
            buf_valid_q   <= 1'b0;
            buf_pc_q      <= 32'd0;
            buf_insn_q    <= 32'd0;
            if_pc_q       <= 32'd0;
            if_pc_plus4_q <= 32'd0;
            if_insn_q     <= NOP_INSN;
            if_en_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            pc_q          <= pc_d;
            buf_valid_q   <= buf_valid_d;
            buf_pc_q      <= buf_pc_d;
            buf_insn_q    <= buf_insn_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_insn_q     <= if_insn_d;
            if_en_q       <= if_en_d;
        end
    end

    assign bus.imem_req    = (state_q == ST_BUSY) || (state_q == ST_DROP);
    assign bus.imem_addr   = req_addr_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_pc_plus4 = if_pc_plus4_q;
    assign bus.if_insn     = if_insn_q;
    assign bus.if_en       = if_en_q;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized stall/redirect traffic against a fetch-order model.
module tb_if_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic chk_on = 1'b0;

    if_stage_if bus ();

    if_stage #(.RESET_PC(RST_PC), .NOP_INSN(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk   = 0;
    int n_fail  = 0;
    int n_deliv = 0;
    int fix_lat = 1;
    int mcnt    = 0;
    int mlat    = 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_tgt();
        if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF8;
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory slave: response after fix_lat cycles (random 1..3 when fix_lat==0), same cycle at latency 1.
    always @(negedge clk) begin
        if (!reset) begin
            mcnt = 0;
            bus.imem_rdy = 1'b0;
            bus.imem_rd_data = 32'hBAD0_BAD0;
        end else if (bus.imem_req) begin
            if (mcnt == 0) mlat = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 3));
            bus.imem_rdy = (mcnt == mlat - 1);
            bus.imem_rd_data = bus.imem_rdy ? mem_word(bus.imem_addr) : 32'hBAD0_BAD0;
            mcnt = bus.imem_rdy ? 0 : mcnt + 1;
        end else begin
            mcnt = 0;
            bus.imem_rdy = 1'b0;
            bus.imem_rd_data = 32'hBAD0_BAD0;
        end
    end

    // Reference model: program-order fetch/delivery with redirect targets, stale responses and a parked word.
    logic        p_req, p_en, start_edge, stale, buffered;
    logic [31:0] p_addr, p_pc, p_pc4, p_insn, exp_pc, exp_fetch;
    logic        c_redir, c_rdy, c_dlv;
    logic [31:0] c_tgt;

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            if (!reset) begin
                start_edge = 1'b1;
                stale      = 1'b0;
                buffered   = 1'b0;
                exp_pc     = RST_PC;
                exp_fetch  = RST_PC;
            end else begin
                c_redir = bus.flush | bus.br_taken;
                c_tgt   = bus.flush ? bus.new_pc : bus.br_addr;
                c_rdy   = p_req & bus.imem_rdy;
                c_dlv   = !c_redir && !bus.stall && ((c_rdy && !stale) || buffered);
                if (c_rdy && !stale && !c_redir) begin
                    chk("fetch_addr", p_addr, exp_fetch);
                    exp_fetch = exp_fetch + 32'd4;
                end
                if (p_req && !bus.imem_rdy) begin
                    chk("req_hold", bus.imem_req, 1'b1);
                    chk("addr_hold", bus.imem_addr, p_addr);
                end
                if (c_rdy && !stale && !c_redir && bus.stall) chk("buf_req_low", bus.imem_req, 1'b0);
                if (c_redir) begin
                    chk("redir_en", bus.if_en, 1'b0);
                    chk("redir_insn", bus.if_insn, NOP);
                end else if (bus.stall) begin
                    chk("stall_pc", bus.if_pc, p_pc);
                    chk("stall_pc4", bus.if_pc_plus4, p_pc4);
                    chk("stall_insn", bus.if_insn, p_insn);
                    chk("stall_en", bus.if_en, p_en);
                end else begin
                    chk("if_en", bus.if_en, c_dlv);
                    if (c_dlv) begin
                        chk("pc_seq", bus.if_pc, exp_pc);
                        chk("pc_plus4", bus.if_pc_plus4, exp_pc + 32'd4);
                        chk("insn", bus.if_insn, mem_word(exp_pc));
                        exp_pc = exp_pc + 32'd4;
                        n_deliv++;
                    end
                end
                if (c_redir && !start_edge) begin
                    exp_pc    = c_tgt;
                    exp_fetch = c_tgt;
                end
                if (c_redir) buffered = 1'b0;
                else if (c_rdy && !stale && bus.stall) buffered = 1'b1;
                else if (!bus.stall) buffered = 1'b0;
                if (c_rdy) stale = 1'b0;
                else if (c_redir && p_req && !start_edge) stale = 1'b1;
                start_edge = 1'b0;
            end
        end
        p_req  = bus.imem_req;
        p_addr = bus.imem_addr;
        p_pc   = bus.if_pc;
        p_pc4  = bus.if_pc_plus4;
        p_insn = bus.if_insn;
        p_en   = bus.if_en;
    end

    task automatic do_reset(input int lat);
        @(negedge clk);
        reset = 1'b0;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0;
        bus.new_pc = 32'd0; bus.br_addr = 32'd0;
        fix_lat = lat;
        chk_on = 1'b1;
        #1;
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_pc", bus.if_pc, 32'd0);
        chk("rst_pc4", bus.if_pc_plus4, 32'd0);
        chk("rst_insn", bus.if_insn, NOP);
        chk("rst_en", bus.if_en, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("start_req", bus.imem_req, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1ms");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic seen;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0;
        bus.new_pc = 32'd0; bus.br_addr = 32'd0;

        // 1-cycle memory: back-to-back fetches, delivery from the second cycle after START
        do_reset(1);
        for (int n = 1; n <= 6; n++) begin
            step();
            chk("t1_req", bus.imem_req, 1'b1);
            chk("t1_addr", bus.imem_addr, 32'(4 * (n - 1)));
            chk("t1_en", bus.if_en, (n >= 2));
            if (n >= 2) begin
                chk("t1_pc", bus.if_pc, 32'(4 * (n - 2)));
                chk("t1_pc4", bus.if_pc_plus4, 32'(4 * (n - 1)));
            end
        end

        // 3-cycle memory: address held three cycles, if_en 0,0,1
        do_reset(3);
        for (int n = 1; n <= 10; n++) begin
            step();
            chk("t2_addr", bus.imem_addr, 32'(4 * ((n - 1) / 3)));
            chk("t2_en", bus.if_en, (n >= 4) && ((n - 4) % 3 == 0));
        end

        // stall as the word for 0x10 returns: buffered, then delivered on release
        do_reset(1);
        repeat (5) step();
        chk("t3_addr10", bus.imem_addr, 32'h10);
        @(negedge clk); bus.stall = 1'b1;
        step();
        chk("t3_req_off", bus.imem_req, 1'b0);
        chk("t3_pc_held", bus.if_pc, 32'h0C);
        step();
        chk("t3_req_off2", bus.imem_req, 1'b0);
        @(negedge clk); bus.stall = 1'b0;
        step();
        chk("t3_insn", bus.if_insn, 32'hDEAD_BEEF);
        chk("t3_pc", bus.if_pc, 32'h10);
        chk("t3_en", bus.if_en, 1'b1);
        chk("t3_next", bus.imem_addr, 32'h14);

        // branch while 0x20 is outstanding: response dropped, refetch at 0x100
        do_reset(3);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            seen = bus.imem_req && (bus.imem_addr == 32'h20);
        end
        chk("t4_wait20", seen, 1'b1);
        @(negedge clk); bus.br_taken = 1'b1; bus.br_addr = 32'h100;
        step();
        chk("t4_drop_req", bus.imem_req, 1'b1);
        chk("t4_drop_addr", bus.imem_addr, 32'h20);
        @(negedge clk); bus.br_taken = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = bus.imem_req && (bus.imem_addr == 32'h100);
        end
        chk("t4_fetch100", seen, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = bus.if_en && (bus.if_pc == 32'h100);
        end
        chk("t4_deliver100", seen, 1'b1);

        // flush, branch and stall together: flush target wins, IF/ID bubbled
        do_reset(1);
        repeat (4) step();
        @(negedge clk);
        bus.flush = 1'b1; bus.new_pc = 32'h200;
        bus.br_taken = 1'b1; bus.br_addr = 32'h300; bus.stall = 1'b1;
        step();
        chk("t5_en", bus.if_en, 1'b0);
        chk("t5_insn", bus.if_insn, NOP);
        chk("t5_addr", bus.imem_addr, 32'h200);
        @(negedge clk);
        bus.flush = 1'b0; bus.br_taken = 1'b0; bus.stall = 1'b0;
        repeat (3) step();

        // asynchronous reset mid-request
        do_reset(3);
        repeat (8) step();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_req", bus.imem_req, 1'b0);
        chk("t6_pc", bus.if_pc, 32'd0);
        chk("t6_pc4", bus.if_pc_plus4, 32'd0);
        chk("t6_insn", bus.if_insn, NOP);
        chk("t6_en", bus.if_en, 1'b0);
        @(negedge clk); reset = 1'b1;
        #1;
        chk("t6_start", bus.imem_req, 1'b0);
        step();
        chk("t6_req_on", bus.imem_req, 1'b1);
        chk("t6_addr", bus.imem_addr, RST_PC);

        // randomized latency, stall and redirects
        do_reset(0);
        n_deliv = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.stall    = ($urandom_range(0, 99) < 25);
            bus.flush    = ($urandom_range(0, 99) < 4);
            bus.br_taken = ($urandom_range(0, 99) < 7);
            bus.new_pc   = rand_tgt();
            bus.br_addr  = rand_tgt();
        end
        @(negedge clk);
        bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0;
        repeat (10) step();
        chk("rand_progress", (n_deliv > 300), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage. Owns the program counter and issues single-outstanding reads on the instruction memory bus.
- Drives the IF/ID pipeline register (if_pc, if_pc_plus4, if_insn, if_en) consumed by the decode stage.
- Honours pipeline stall, flush and branch redirects.
- Holds at most one early-returned instruction in a one-entry buffer so no fetched word is lost under stall.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSN, 32'h0000_0000, instruction word driven on if_insn when if_en=0 after reset/flush

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request; held high until imem_rdy
imem_addr  output  32  fetch address; stable while imem_req=1
imem_rd_data  input  32  instruction word, valid when imem_rdy=1
imem_rdy  input  1  response strobe; 1 cycle per request, latency ≥1 cycle
stall  input  1  hold IF/ID register and stop accepting new words
flush  input  1  pipeline flush; redirect to new_pc
new_pc  input  32  flush target
br_taken  input  1  branch/jump resolved in decode; redirect to br_addr
br_addr  input  32  branch target
if_pc  output  32  PC of instruction in IF/ID
if_pc_plus4  output  32  if_pc+4 (link address)
if_insn  output  32  instruction in IF/ID
if_en  output  1  IF/ID contents valid

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - if_pc=0, if_pc_plus4=0, if_insn=NOP_INSN, if_en=0, buf_valid=0.
  - req_addr=RESET_PC, pc=RESET_PC+4, state=START.
- imem_req=1 iff state is BUSY or DROP; imem_addr=req_addr. Both are purely registered-state driven.
- Redirect = flush | br_taken. Target = new_pc if flush, else br_addr (flush has priority). Redirect has priority over stall.
- Every redirect at an edge: if_en<=0, if_insn<=NOP_INSN; if_pc and if_pc_plus4 are don't-care-held.
- Stall without redirect: if_pc, if_pc_plus4, if_insn and if_en all hold.
- No stall, no redirect, no word delivered this cycle: if_en<=0 (bubble).
- "Deliver w from address a" means: if_pc<=a, if_pc_plus4<=a+4, if_insn<=w, if_en<=1. All PC arithmetic is mod 2^32 and wraps silently.
- State machine:
  - START: -> BUSY, next cycle.
  - BUSY, imem_rdy=1:
    - redirect: discard word; req_addr<=target, pc<=target+4; stay BUSY.
    - stall: buffer word (buf_valid<=1, buf_pc<=req_addr, buf_insn<=imem_rd_data); -> HOLD.
    - else: deliver imem_rd_data from req_addr; req_addr<=pc, pc<=pc+4; stay BUSY.
  - BUSY, imem_rdy=0:
    - redirect: pc<=target; -> DROP. The request stays asserted with the old address, per bus rule.
    - else: stay BUSY.
  - DROP (discard outstanding response):
    - redirect: pc<=target.
    - imem_rdy=1: word discarded; req_addr<=pc (or the target if redirect is asserted the same cycle), pc<=that+4; -> BUSY.
  - HOLD (imem_req=0, buf_valid=1):
    - redirect: buf_valid<=0; req_addr<=target, pc<=target+4; -> BUSY.
    - !stall: deliver buf_insn from buf_pc; buf_valid<=0; req_addr<=pc, pc<=pc+4; -> BUSY.
    - stall: stay.
- Throughput: 1 instruction/cycle with 1-cycle memory, no stall.
- Latency: first if_en=1 at the edge where the first imem_rdy is sampled.
- imem_rdy outside BUSY/DROP is a protocol error and is ignored.
- Reset mid-request: state returns to START. The bus slave must drop any pending response on reset.

Test Plan:
- 1-cycle memory returning addr-derived words, RESET_PC=0 -> imem_addr 0,4,8,… on consecutive cycles. if_en=1 from 2nd cycle after START, if_pc=0,4,8; if_pc_plus4=if_pc+4.
- 3-cycle memory latency -> imem_req/imem_addr stable 3 cycles per fetch; if_en pattern 0,0,1 repeating.
- stall=1 in the cycle imem_rdy returns word 0xDEAD_BEEF for pc 0x10 -> IF/ID holds, imem_req=0 while stalled. On release, if_insn=0xDEAD_BEEF, if_pc=0x10; next imem_addr=0x14.
- br_taken=1 with br_addr=0x100 while fetch of 0x20 is pending -> DROP. Word for 0x20 never appears with if_en=1; next imem_addr=0x100; then if_pc=0x100 with if_en=1.
- flush=1 (new_pc=0x200) and br_taken=1 (br_addr=0x300) and stall=1 together -> if_en=0, if_insn=NOP_INSN; next fetch address 0x200.
- Assert reset low during BUSY wait -> all outputs immediately at reset values, imem_req=0. After release: one START cycle, then imem_addr=RESET_PC.
